store_split_unit: RTL and testbench
===================================

// Module: store_split_unit
// PURPOSE
//  Successor to the combinational store encoder. Takes one store request (SB/SH/SW, plus SD when XLEN=64),
//  aligns its data and byte strobes to the bus, and issues them as bus beats over a valid/ready handshake.
//  A store that crosses a bus-word boundary is split into two beats. Sits between the LSU and the data-memory port.
// PARAMETERS
//  XLEN    32  data/bus width in bits; 32 or 64; NB = XLEN/8 byte lanes, OW = log2(NB)
//  ADDR_W  32  byte-address width
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high reset
//  req_valid  in   1       store request valid
//  req_ready  out  1       unit can accept a request (high only in IDLE)
//  req_type   in   2       00 SB, 01 SH, 10 SW, 11 SD (legal only when XLEN=64)
//  req_addr   in   ADDR_W  byte address (any alignment)
//  req_data   in   XLEN    store data, right-justified
//  mem_valid  out  1       bus beat valid
//  mem_ready  in   1       bus accepts beat
//  mem_addr   out  ADDR_W  bus-word-aligned address (low OW bits 0)
//  mem_wdata  out  XLEN    beat write data; bytes outside mem_wstrb are 0
//  mem_wstrb  out  NB      byte-lane enables
//  done       out  1       one-cycle pulse: request fully written
//  err        out  1       one-cycle pulse: illegal req_type, request dropped
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, done=0, err=0.
//  Accept: on a rising edge with state IDLE and req_valid=1; latch type, addr, data.
//  Alignment: size = 1<<req_type bytes; off = req_addr[OW-1:0].
//    wide_data[2*XLEN-1:0] = zero-extended(req_data masked to size) << 8*off.
//    wide_strb[2*NB-1:0] = ((1<<size)-1) << off.
//    Beat0: addr = {req_addr[ADDR_W-1:OW], OW'0}, wstrb/wdata = low halves of wide_strb/wide_data.
//    Beat1: needed iff the upper half of wide_strb != 0; addr = beat0 addr + NB, modulo 2^ADDR_W (wraps to 0).
//  FSM:
//    IDLE  -accept, legal type-> BEAT0. -accept, illegal type-> ERR.
//    BEAT0 -mem_ready & split-> BEAT1. -mem_ready & !split-> IDLE with done pulse.
//    BEAT1 -mem_ready-> IDLE with done pulse.
//    ERR   -> IDLE next cycle; err=1 in ERR; no mem_valid.
//  Timing: accept at edge N -> mem_valid=1 with beat0 from cycle N+1 (registered outputs, no combinational
//    path from req_* to mem_*). A beat completes on an edge with mem_valid&mem_ready; beat1 is presented the
//    cycle after beat0 completes. done is high for exactly the cycle after the final completing edge; req_ready
//    is high in that same cycle, so back-to-back requests are possible.
//  Handshake: while mem_valid=1 and mem_ready=0, mem_addr/mem_wdata/mem_wstrb stay stable; mem_valid never drops
//    before acceptance. req_* are ignored outside IDLE.
//  SD when XLEN=32 -> illegal; every other type is legal at any offset (misaligned allowed, split as needed).
//  SB never splits. done and err are never high together.
//  Reset mid-operation: in-flight request abandoned; all outputs return to reset values at that edge; no done.
// TESTING
//  XLEN=32, SB addr 0x103 data 0x000000FF, mem_ready=1 -> one beat: addr 0x100, wstrb 4'b1000,
//    wdata 0xFF000000; done one cycle later.
//  XLEN=32, SW addr 0x1002 data 0xAABBCCDD -> beat0 addr 0x1000 wstrb 1100 wdata 0xCCDD0000;
//    beat1 addr 0x1004 wstrb 0011 wdata 0x0000AABB; single done pulse.
//  SH addr 0x2 data 0xFFFF1234 with mem_ready low for 3 cycles -> addr 0x0, wstrb 1100, wdata 0x12340000
//    held stable throughout; req_ready=0 until done.
//  XLEN=32, type 11 -> err pulse one cycle, mem_valid stays 0, req_ready high again the cycle after.
//  SW addr 0xFFFFFFFE -> beat0 addr 0xFFFFFFFC wstrb 1100; beat1 addr 0x00000000 wstrb 0011.
//  reset asserted while beat1 pending -> mem_valid=0 after that edge, no done; XLEN=64 SD addr 0x5
//    -> wstrb 8'hE0 then 8'h1F.

Source files
------------

// File: rtl/store_split_if.sv
// Store request / data-memory bus bundle for store_split_unit.
//   slave  : the store split unit's view. It takes requests and mem_ready, and drives
//            req_ready, the bus beat, done and err.
//   master : the environment's view (LSU + memory), with the opposite directions.
// Request side: req_valid, req_ready, req_type, req_addr, req_data.
// Bus side    : mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb.
// Status      : done, err (one-cycle pulses).
interface store_split_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [NB-1:0]     mem_wstrb;
    logic              done;
    logic              err;

    modport slave (
        input  req_valid, req_type, req_addr, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
    );

    modport master (
        output req_valid, req_type, req_addr, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
    );
endinterface

// File: rtl/store_split_unit.sv
// Store split unit: accepts one store request (SB/SH/SW, plus SD when XLEN=64),
// aligns data and byte strobes to the bus word, and issues one or two bus beats
// over a valid/ready handshake. A store crossing a bus-word boundary is split.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    store_split_if.slave (request in, bus beat out, done/err pulses)
// All bus-side outputs are registered; there is no combinational path from req_* to mem_*.
module store_split_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_split_if.slave  bus
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StErr} state_e;

    state_e            state_q;
    logic              mem_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [NB-1:0]     mem_wstrb_q;
    logic [XLEN-1:0]   hi_wdata_q;
    logic [NB-1:0]     hi_wstrb_q;
    logic              done_q;
    logic              err_q;

    // Alignment of the incoming request (only consumed on the accepting edge).
    int unsigned       size_bytes;
    logic [OW-1:0]     off;
    logic [NB-1:0]     strb_base;
    logic [XLEN-1:0]   data_m;
    logic [2*NB-1:0]   wide_strb;
    logic [2*XLEN-1:0] wide_data;
    logic              legal;

    always_comb begin
        unique case (bus.req_type)
            2'b00:   size_bytes = 1;
            2'b01:   size_bytes = 2;
            2'b10:   size_bytes = 4;
            default: size_bytes = 8;
        endcase
        off = bus.req_addr[OW-1:0];
        for (int i = 0; i < int'(NB); i++) begin
            strb_base[i]   = (i < int'(size_bytes));
            data_m[8*i +: 8] = strb_base[i] ? bus.req_data[8*i +: 8] : 8'h00;
        end
        wide_strb = {{NB{1'b0}}, strb_base} << off;
        wide_data = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
        legal     = (XLEN == 64) || (bus.req_type != 2'b11);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            hi_wdata_q  <= '0;
            hi_wstrb_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        if (legal) begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {bus.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                            mem_wdata_q <= wide_data[XLEN-1:0];
                            mem_wstrb_q <= wide_strb[NB-1:0];
                            hi_wdata_q  <= wide_data[2*XLEN-1:XLEN];
                            hi_wstrb_q  <= wide_strb[2*NB-1:NB];
                            state_q     <= StBeat0;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StErr;
                        end
                    end
                end
                StBeat0: begin
                    if (bus.mem_ready) begin
                        if (hi_wstrb_q != '0) begin
                            // Address wraps modulo 2^ADDR_W.
                            mem_addr_q  <= mem_addr_q + ADDR_W'(NB);
                            mem_wdata_q <= hi_wdata_q;
                            mem_wstrb_q <= hi_wstrb_q;
                            state_q     <= StBeat1;
                        end else begin
                            mem_valid_q <= 1'b0;
                            mem_addr_q  <= '0;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= '0;
                            done_q      <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end
                end
                StBeat1: begin
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                        done_q      <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_store_split_unit.sv
// Directed bench for store_split_unit: a 32-bit instance for most vectors and a
// 64-bit instance for the SD split case. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_store_split_unit;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    store_split_if #(.XLEN(32), .ADDR_W(32)) b32 ();
    store_split_if #(.XLEN(64), .ADDR_W(32)) b64 ();

    store_split_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (b32.slave)
    );

    store_split_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (b64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req32(input logic v, input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] d);
        b32.req_valid = v;
        b32.req_type  = t;
        b32.req_addr  = a;
        b32.req_data  = d;
    endtask

    task automatic beat32(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        check({tag, ".valid"}, 64'(b32.mem_valid), 64'd1);
        check({tag, ".addr"},  64'(b32.mem_addr),  64'(a));
        check({tag, ".wstrb"}, 64'(b32.mem_wstrb), 64'(s));
        check({tag, ".wdata"}, 64'(b32.mem_wdata), 64'(d));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        req32(1'b0, 2'b00, 32'h0, 32'h0);
        b32.mem_ready = 1'b0;
        b64.req_valid = 1'b0;
        b64.req_type  = 2'b00;
        b64.req_addr  = 32'h0;
        b64.req_data  = 64'h0;
        b64.mem_ready = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst.req_ready", 64'(b32.req_ready), 64'd1);
        check("rst.mem_valid", 64'(b32.mem_valid), 64'd0);
        check("rst.mem_addr",  64'(b32.mem_addr),  64'd0);
        check("rst.mem_wdata", 64'(b32.mem_wdata), 64'd0);
        check("rst.mem_wstrb", 64'(b32.mem_wstrb), 64'd0);
        check("rst.done",      64'(b32.done),      64'd0);
        check("rst.err",       64'(b32.err),       64'd0);
        check("rst64.valid",   64'(b64.mem_valid), 64'd0);
        reset = 1'b0;
        tick();

        // SB at offset 3: single beat.
        req32(1'b1, 2'b00, 32'h0000_0103, 32'h0000_00FF);
        b32.mem_ready = 1'b1;
        tick();
        req32(1'b0, 2'b00, 32'h0, 32'h0);
        beat32("sb", 32'h100, 4'b1000, 32'hFF00_0000);
        check("sb.req_ready", 64'(b32.req_ready), 64'd0);
        check("sb.done_early", 64'(b32.done), 64'd0);
        tick();
        check("sb.done", 64'(b32.done), 64'd1);
        check("sb.valid_off", 64'(b32.mem_valid), 64'd0);
        check("sb.req_ready_done", 64'(b32.req_ready), 64'd1);

        // Back-to-back: SW at 0x1002 accepted in the done cycle, splits in two.
        req32(1'b1, 2'b10, 32'h0000_1002, 32'hAABB_CCDD);
        tick();
        req32(1'b0, 2'b00, 32'h0, 32'h0);
        check("sw.done_clear", 64'(b32.done), 64'd0);
        beat32("sw.b0", 32'h1000, 4'b1100, 32'hCCDD_0000);
        tick();
        beat32("sw.b1", 32'h1004, 4'b0011, 32'h0000_AABB);
        check("sw.no_done_mid", 64'(b32.done), 64'd0);
        tick();
        check("sw.done", 64'(b32.done), 64'd1);
        check("sw.valid_off", 64'(b32.mem_valid), 64'd0);
        tick();
        check("sw.done_once", 64'(b32.done), 64'd0);

        // SH at offset 2 with 3 stall cycles; new requests ignored while busy.
        b32.mem_ready = 1'b0;
        req32(1'b1, 2'b01, 32'h0000_0002, 32'hFFFF_1234);
        tick();
        req32(1'b1, 2'b10, 32'h0000_0555, 32'h5555_5555);
        for (int i = 0; i < 3; i++) begin
            beat32("sh.stall", 32'h0, 4'b1100, 32'h1234_0000);
            check("sh.req_ready", 64'(b32.req_ready), 64'd0);
            check("sh.done_stall", 64'(b32.done), 64'd0);
            tick();
        end
        beat32("sh.final", 32'h0, 4'b1100, 32'h1234_0000);
        req32(1'b0, 2'b00, 32'h0, 32'h0);
        b32.mem_ready = 1'b1;
        tick();
        check("sh.done", 64'(b32.done), 64'd1);
        check("sh.req_ready_done", 64'(b32.req_ready), 64'd1);
        check("sh.valid_off", 64'(b32.mem_valid), 64'd0);
        tick();

        // SD on a 32-bit bus is illegal.
        req32(1'b1, 2'b11, 32'h0000_0040, 32'h1234_5678);
        tick();
        req32(1'b0, 2'b00, 32'h0, 32'h0);
        check("sd32.err", 64'(b32.err), 64'd1);
        check("sd32.valid", 64'(b32.mem_valid), 64'd0);
        check("sd32.done", 64'(b32.done), 64'd0);
        check("sd32.req_ready", 64'(b32.req_ready), 64'd0);
        tick();
        check("sd32.err_clear", 64'(b32.err), 64'd0);
        check("sd32.req_ready_back", 64'(b32.req_ready), 64'd1);
        check("sd32.valid_after", 64'(b32.mem_valid), 64'd0);

        // SW at top of address space: beat1 wraps to 0.
        req32(1'b1, 2'b10, 32'hFFFF_FFFE, 32'h1122_3344);
        tick();
        req32(1'b0, 2'b00, 32'h0, 32'h0);
        beat32("wrap.b0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
        tick();
        beat32("wrap.b1", 32'h0000_0000, 4'b0011, 32'h0000_1122);
        tick();
        check("wrap.done", 64'(b32.done), 64'd1);
        tick();

        // Reset while beat1 is pending: abandoned, no done.
        req32(1'b1, 2'b10, 32'h0000_1002, 32'hAABB_CCDD);
        tick();
        req32(1'b0, 2'b00, 32'h0, 32'h0);
        beat32("rstmid.b0", 32'h1000, 4'b1100, 32'hCCDD_0000);
        tick();
        beat32("rstmid.b1", 32'h1004, 4'b0011, 32'h0000_AABB);
        b32.mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid.valid", 64'(b32.mem_valid), 64'd0);
        check("rstmid.done", 64'(b32.done), 64'd0);
        check("rstmid.addr", 64'(b32.mem_addr), 64'd0);
        check("rstmid.wstrb", 64'(b32.mem_wstrb), 64'd0);
        check("rstmid.req_ready", 64'(b32.req_ready), 64'd1);
        b32.mem_ready = 1'b1;
        tick();
        check("rstmid.done_after", 64'(b32.done), 64'd0);
        check("rstmid.valid_after", 64'(b32.mem_valid), 64'd0);

        // 64-bit bus: SD at offset 5 splits 0xE0 / 0x1F.
        b64.req_valid = 1'b1;
        b64.req_type  = 2'b11;
        b64.req_addr  = 32'h0000_0005;
        b64.req_data  = 64'h0102_0304_0506_0708;
        b64.mem_ready = 1'b1;
        tick();
        b64.req_valid = 1'b0;
        check("sd64.b0.valid", 64'(b64.mem_valid), 64'd1);
        check("sd64.b0.addr",  64'(b64.mem_addr),  64'h0);
        check("sd64.b0.wstrb", 64'(b64.mem_wstrb), 64'hE0);
        check("sd64.b0.wdata", b64.mem_wdata,      64'h0607_0800_0000_0000);
        check("sd64.err",      64'(b64.err),       64'd0);
        tick();
        check("sd64.b1.addr",  64'(b64.mem_addr),  64'h8);
        check("sd64.b1.wstrb", 64'(b64.mem_wstrb), 64'h1F);
        check("sd64.b1.wdata", b64.mem_wdata,      64'h0000_0001_0203_0405);
        tick();
        check("sd64.done", 64'(b64.done), 64'd1);
        check("sd64.valid_off", 64'(b64.mem_valid), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
